peridot_i2c_seq: RTL and testbench

PERIDOT_I2C_SEQ -- requirements
Module: peridot_i2c_seq

---
 rtl/peridot_i2c_seq.sv | 178 +++++++++++++++++
 tb/tb_peridot_i2c_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peridot_i2c_seq.sv
// peridot_i2c_seq
// Queues byte-level I2C commands and plays them into an I2C master through its
// two-register access port. At start-up the master is taken out of reset and
// given its SCL divider; afterwards each command is issued once the master
// reports ready, and the master's response is returned.
//
// Optional feature (macro PERIDOT_I2C_SEQ_NACKABORT_EN): a write answered with
// NACK flushes every queued command and sets the sticky err flag. Without the
// macro, err is tied low and err_clr is ignored.
//
// Ports
//   clock_sig, reset_sig     rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready      command push; cmd_data = {sta, stp, rd_nwr, nack, txdata[7:0]}
//   rsp_valid/rsp_ready      response handshake; rsp_data = {ack_bit, rxdata[7:0]}
//   m_address, m_write,      master register select and single-cycle strobes
//   m_read, m_writedata
//   m_readdata               master read data, valid in the cycle m_read is high
//   busy                     low only in IDLE with the command queue empty
//   err, err_clr             sticky abort flag and its clear
//
// state    | meaning
// CFG_RST  | write control word, releasing the master's device reset
// CFG_POLL | read status until the master reports ready
// CFG_DIV  | repeat the control write so the divider is taken while ready
// IDLE     | wait for a queued command
// CHECK    | read status until ready, then pop the queue head
// ISSUE    | write the command word
// GAP      | one quiet cycle so the master's ready has dropped
// POLL     | read status until ready, capture the response
// RESP     | present the response until accepted
module peridot_i2c_seq #(
    parameter logic [9:0] CLKDIV     = 10'd124,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic        clock_sig,
    input  logic        reset_sig,
    input  logic        cmd_valid,
    input  logic [11:0] cmd_data,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [8:0]  rsp_data,
    input  logic        rsp_ready,
    output logic        m_address,
    output logic        m_write,
    output logic        m_read,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [31:0]         CFG_WORD = {22'd0, CLKDIV};

    typedef enum logic [3:0] {
        CFG_RST, CFG_POLL, CFG_DIV, IDLE, CHECK, ISSUE, GAP, POLL, RESP
    } state_t;

    state_t                state, state_nxt;
    logic [11:0]           fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   fifo_cnt;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop, flush, mst_ready;
    logic [11:0]           cur_cmd;
    logic [21:0]           unused_rdata;

    assign unused_rdata = m_readdata[31:10];
    assign mst_ready    = m_readdata[9];
    assign fifo_empty   = (fifo_cnt == '0);
    assign fifo_full    = (fifo_cnt == FULL_CNT);
    assign pop          = (state == CHECK) && mst_ready;
    // A pop in the same cycle frees a slot, so a full queue may still accept.
    assign cmd_ready    = !reset_sig && (!fifo_full || pop);
    assign push         = cmd_valid && cmd_ready;

`ifdef PERIDOT_I2C_SEQ_NACKABORT_EN
    logic err_q;
    // Abort decided on the POLL->RESP transition of a write that saw NACK.
    assign flush = (state == POLL) && mst_ready && !cur_cmd[9] && m_readdata[8];

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig)    err_q <= 1'b0;
        else if (flush)   err_q <= 1'b1;
        else if (err_clr) err_q <= 1'b0;
    end
    assign err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign flush          = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clock_sig) begin
        if (push) fifo_mem[wr_ptr] <= cmd_data;
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (flush) begin
                // Everything already queued is dropped; a same-cycle push survives.
                rd_ptr   <= wr_ptr;
                fifo_cnt <= {{DEPTH_LOG2{1'b0}}, push};
            end else begin
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                    2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            cur_cmd  <= '0;
            rsp_data <= '0;
        end else begin
            if (pop) cur_cmd <= fifo_mem[rd_ptr];
            if ((state == POLL) && mst_ready) rsp_data <= m_readdata[8:0];
        end
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) state <= CFG_RST;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CFG_RST:  state_nxt = CFG_POLL;
            CFG_POLL: if (mst_ready) state_nxt = CFG_DIV;
            CFG_DIV:  state_nxt = IDLE;
            IDLE:     if (!fifo_empty) state_nxt = CHECK;
            CHECK:    if (mst_ready) state_nxt = ISSUE;
            ISSUE:    state_nxt = GAP;
            GAP:      state_nxt = POLL;
            POLL:     if (mst_ready) state_nxt = RESP;
            RESP:     if (rsp_ready) state_nxt = IDLE;
            default:  state_nxt = CFG_RST;
        endcase
    end

    // Strobes are held off while reset is high, so the CFG_RST write is
    // taken on the first clock edge after release.
    always_comb begin
        m_write     = 1'b0;
        m_read      = 1'b0;
        m_address   = 1'b0;
        m_writedata = '0;
        rsp_valid   = (state == RESP);
        busy        = !((state == IDLE) && fifo_empty);
        if (!reset_sig) begin
            case (state)
                CFG_RST, CFG_DIV: begin
                    m_write     = 1'b1;
                    m_address   = 1'b1;
                    m_writedata = CFG_WORD;
                end
                CFG_POLL, CHECK, POLL: m_read = 1'b1;
                ISSUE: begin
                    m_write     = 1'b1;
                    m_writedata = {19'd0, cur_cmd[11:9], 1'b1, cur_cmd[8:0]};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_peridot_i2c_seq.sv
module tb_peridot_i2c_seq;
    logic        clock_sig = 1'b0;
    logic        reset_sig = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [11:0] cmd_data  = '0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [8:0]  rsp_data;
    logic        rsp_ready = 1'b0;
    logic        m_address, m_write, m_read;
    logic [31:0] m_writedata, m_readdata;
    logic        busy, err;
    logic        err_clr = 1'b0;

    always #5 clock_sig = ~clock_sig;

    peridot_i2c_seq dut (
        .clock_sig(clock_sig), .reset_sig(reset_sig),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .m_address(m_address), .m_write(m_write), .m_read(m_read),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    // Per-command plan, indexed by issue order: master latency, response, expected write word.
    int          plan_lat [64];
    logic [8:0]  plan_rsp [64];
    logic [31:0] plan_wd  [64];
    int          n_plan = 0;
    int          n_rsp  = 0;

    // I2C master model: not ready for 5 cycles after reset, then busy for the
    // planned latency after every command write.
    int         boot_cnt = 5;
    int         mdl_cnt  = 0;
    int         mdl_idx  = 0;
    logic       mdl_busy = 1'b0;
    logic [8:0] mdl_rsp  = '0;

    always @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            boot_cnt <= 5;
            mdl_busy <= 1'b0;
            mdl_cnt  <= 0;
            mdl_rsp  <= '0;
        end else begin
            if (boot_cnt > 0) boot_cnt <= boot_cnt - 1;
            if (m_write && !m_address) begin
                mdl_busy <= 1'b1;
                mdl_cnt  <= plan_lat[mdl_idx % 64];
                mdl_rsp  <= plan_rsp[mdl_idx % 64];
                mdl_idx  <= mdl_idx + 1;
            end else if (mdl_busy) begin
                if (mdl_cnt <= 1) mdl_busy <= 1'b0;
                else              mdl_cnt  <= mdl_cnt - 1;
            end
        end
    end
    assign m_readdata = {22'd0, (boot_cnt == 0) && !mdl_busy, mdl_rsp};

    // Bus monitor, sampled mid-cycle.
    int          cfg_n = 0, iss_n = 0, rd_n = 0;
    logic [31:0] cfg_wd [8];
    logic [31:0] iss_wd [64];
    logic        overlap = 1'b0;
    always @(negedge clock_sig) begin
        if (m_write && m_read) overlap <= 1'b1;
        if (m_read) rd_n <= rd_n + 1;
        if (m_write && m_address) begin
            cfg_wd[cfg_n % 8] <= m_writedata;
            cfg_n <= cfg_n + 1;
        end
        if (m_write && !m_address) begin
            iss_wd[iss_n % 64] <= m_writedata;
            iss_n <= iss_n + 1;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_sig);
        #1;
    endtask

    task automatic plan_add(input logic [11:0] c, input int lat, input logic [8:0] rsp);
        plan_lat[n_plan % 64] = lat;
        plan_rsp[n_plan % 64] = rsp;
        plan_wd[n_plan % 64]  = 32'(4096 * int'(c[11]) + 2048 * int'(c[10]) + 1024 * int'(c[9])
                                    + 512 + 256 * int'(c[8]) + int'(c[7:0]));
        n_plan++;
    endtask

    task automatic push(input logic [11:0] c, input int lat, input logic [8:0] rsp);
        int k = 0;
        plan_add(c, lat, rsp);
        cmd_data  = c;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && k < 100) begin step(); k++; end
        chk("push cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int k = 0;
        while (rsp_valid !== 1'b1 && k < 200) begin step(); k++; end
        chk({tag, " rsp_valid"}, rsp_valid, 1);
    endtask

    task automatic take_rsp(input string tag, input int dly);
        wait_rsp(tag);
        chk({tag, " rsp_data"}, rsp_data, plan_rsp[n_rsp % 64]);
        chk({tag, " writedata"}, iss_wd[n_rsp % 64], plan_wd[n_rsp % 64]);
        if (dly > 0) begin
            repeat (dly) step();
            chk({tag, " hold valid"}, rsp_valid, 1);
            chk({tag, " hold data"}, rsp_data, plan_rsp[n_rsp % 64]);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_rsp++;
        chk({tag, " rsp_valid drop"}, rsp_valid, 0);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 100) begin step(); k++; end
        chk({tag, " busy"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int c0;
        int i0;
        #1 reset_sig = 1'b1;
        repeat (3) @(posedge clock_sig);
        #1;
        chk("rst m_read", m_read, 0);
        chk("rst m_write", m_write, 0);
        chk("rst m_address", m_address, 0);
        chk("rst m_writedata", m_writedata, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_data", rsp_data, 0);
        chk("rst busy", busy, 1);
        chk("rst cmd_ready", cmd_ready, 0);
        chk("rst err", err, 0);
        #1 reset_sig = 1'b0;
        step();
        chk("boot cmd_ready", cmd_ready, 1);
        chk("boot busy", busy, 1);
        wait_idle("boot");
        chk("boot cfg writes", cfg_n, 2);
        chk("boot cfg word0", cfg_wd[0], 32'h0000007C);
        chk("boot cfg word1", cfg_wd[1], 32'h0000007C);
        chk("boot status reads", rd_n, 5);

        push({1'b1, 1'b0, 1'b0, 1'b0, 8'hA0}, 20, 9'h0A0);
        take_rsp("wr_a0", 2);
        chk("wr_a0 word literal", iss_wd[0], 32'h000012A0);

        push({1'b0, 1'b1, 1'b1, 1'b1, 8'h00}, 5, 9'h05C);
        take_rsp("rd_5c", 0);
        chk("rd_5c word literal", iss_wd[1], 32'h00000F00);

        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 3; j++) begin
                logic [11:0] r;
                logic [8:0]  rv;
                r  = 12'($urandom);
                rv = r[9] ? 9'($urandom) : {1'b0, 8'($urandom)};
                push(r, int'($urandom_range(1, 12)), rv);
            end
            for (int j = 0; j < 3; j++) take_rsp("rand", int'($urandom_range(0, 3)));
        end

        // Fill the queue while one response is held, then push into the pop slot.
        push({1'b0, 1'b0, 1'b1, 1'b0, 8'h11}, 2, 9'h0AA);
        wait_rsp("full hold");
        for (int j = 0; j < 16; j++) push({1'b1, 1'b1, 1'b0, 1'b0, 8'(j)}, int'($urandom_range(1, 3)), {1'b0, 8'($urandom)});
        chk("full cmd_ready", cmd_ready, 0);
        plan_add({1'b0, 1'b1, 1'b0, 1'b0, 8'h77}, 1, 9'h033);
        cmd_data  = {1'b0, 1'b1, 1'b0, 1'b0, 8'h77};
        cmd_valid = 1'b1;
        take_rsp("full first", 0);
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin step(); k++; end
        chk("full pop window", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("full after push+pop", cmd_ready, 0);
        for (int j = 0; j < 17; j++) take_rsp("full drain", 0);
        wait_idle("full drained");

        // Write answered with NACK while three more commands wait.
        push({1'b1, 1'b0, 1'b0, 1'b0, 8'h3C}, 15, 9'h1A5);
        for (int j = 0; j < 3; j++) push({1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom)}, 2, 9'h000);
        wait_rsp("nack");
`ifdef PERIDOT_I2C_SEQ_NACKABORT_EN
        chk("nack err set", err, 1);
        take_rsp("nack", 0);
        chk("nack queue flushed", busy, 0);
        chk("nack err sticky", err, 1);
        n_plan = n_plan - 3;
        repeat (5) step();
        chk("nack no further issue", iss_n, n_rsp);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("nack err cleared", err, 0);
`else
        chk("nack err tied low", err, 0);
        take_rsp("nack", 0);
        for (int j = 0; j < 3; j++) take_rsp("nack kept", 0);
        wait_idle("nack kept");
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("nack err after clr", err, 0);
`endif

        // Reset in the middle of a POLL with commands still queued.
        i0 = iss_n;
        push({1'b0, 1'b0, 1'b1, 1'b0, 8'h00}, 20, 9'h055);
        push({1'b0, 1'b0, 1'b1, 1'b0, 8'h01}, 2, 9'h056);
        push({1'b0, 1'b0, 1'b1, 1'b0, 8'h02}, 2, 9'h057);
        k = 0;
        while (!(iss_n > i0 && m_read === 1'b1) && k < 50) begin step(); k++; end
        chk("poll reached", m_read, 1);
        c0 = cfg_n;
        reset_sig = 1'b1;
        #1;
        chk("midrst m_read", m_read, 0);
        chk("midrst m_write", m_write, 0);
        chk("midrst rsp_valid", rsp_valid, 0);
        chk("midrst busy", busy, 1);
        chk("midrst cmd_ready", cmd_ready, 0);
        repeat (2) @(posedge clock_sig);
        #2 reset_sig = 1'b0;
        wait_idle("midrst reboot");
        chk("midrst cfg writes", cfg_n, c0 + 2);
        chk("midrst cfg word0", cfg_wd[c0 % 8], 32'h0000007C);
        chk("midrst cfg word1", cfg_wd[(c0 + 1) % 8], 32'h0000007C);
        repeat (5) step();
        chk("midrst queue empty", iss_n, i0 + 1);
        chk("no read/write overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
